// File: rtl/wb_arbiter.sv
// Write-back arbiter: holds one pending result per producer and drains up to WRITE
// of them per cycle, round-robin, into registered active-low register-file write ports.
module wb_arbiter #(
    parameter int DATA  = 32,
    parameter int ADDR  = 4,
    parameter int SRC   = 4,
    parameter int WRITE = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SRC-1:0]              src_valid,
    output logic [SRC-1:0]              src_ready,
    input  logic [SRC-1:0][ADDR-1:0]    src_addr,
    input  logic [SRC-1:0][DATA-1:0]    src_data,
    output logic [WRITE-1:0]            we_,
    output logic [WRITE-1:0][ADDR-1:0]  waddr,
    output logic [WRITE-1:0][DATA-1:0]  wdata,
    output logic                        idle
);

    localparam int PTR_W = $clog2(SRC);

    logic [SRC-1:0]             held_q, held_d;
    logic [SRC-1:0][ADDR-1:0]   h_addr_q, h_addr_d;
    logic [SRC-1:0][DATA-1:0]   h_data_q, h_data_d;
    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [WRITE-1:0]           we_q, we_d;
    logic [WRITE-1:0][ADDR-1:0] waddr_q, waddr_d;
    logic [WRITE-1:0][DATA-1:0] wdata_q, wdata_d;
    logic [SRC-1:0]             grant;

    // Scan from rr_ptr; waddr_d doubles as the list of addresses already granted,
    // so a held entry colliding with one of them waits for a later cycle.
    always_comb begin
        int               n_grant;
        int               idx;
        logic [PTR_W-1:0] sel;
        logic             conflict;
        grant    = '0;
        we_d     = '1;
        waddr_d  = '0;
        wdata_d  = '0;
        rr_ptr_d = rr_ptr_q;
        n_grant  = 0;
        idx      = 0;
        sel      = '0;
        conflict = 1'b0;
        for (int j = 0; j < SRC; j++) begin
            idx = int'(rr_ptr_q) + j;
            if (idx >= SRC) idx = idx - SRC;
            sel = PTR_W'(idx);
            conflict = 1'b0;
            for (int k = 0; k < WRITE; k++) begin
                if (k < n_grant && waddr_d[k] == h_addr_q[sel]) conflict = 1'b1;
            end
            if (held_q[sel] && n_grant < WRITE && !conflict) begin
                grant[sel] = 1'b1;
                for (int k = 0; k < WRITE; k++) begin
                    if (k == n_grant) begin
                        we_d[k]    = 1'b0;
                        waddr_d[k] = h_addr_q[sel];
                        wdata_d[k] = h_data_q[sel];
                    end
                end
                n_grant  = n_grant + 1;
                rr_ptr_d = (sel == PTR_W'(SRC - 1)) ? '0 : sel + 1'b1;
            end
        end
    end

    always_comb begin
        src_ready = reset ? '0 : (~held_q | grant);
        held_d    = held_q;
        h_addr_d  = h_addr_q;
        h_data_d  = h_data_q;
        for (int i = 0; i < SRC; i++) begin
            if (src_valid[i] && src_ready[i]) begin
                held_d[i]   = 1'b1;
                h_addr_d[i] = src_addr[i];
                h_data_d[i] = src_data[i];
            end else if (grant[i]) begin
                held_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held_q   <= '0;
            h_addr_q <= '0;
            h_data_q <= '0;
            rr_ptr_q <= '0;
            we_q     <= '1;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            held_q   <= held_d;
            h_addr_q <= h_addr_d;
            h_data_q <= h_data_d;
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign we_   = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign idle  = reset | (~|held_q & &we_q);

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter; two instances (WRITE=1, WRITE=2) are
// compared every cycle against a queue-style reference model of the arbitration rules.
module tb_wb_arbiter;

    logic                  clk;
    logic                  reset;
    logic [3:0]            src_valid;
    logic [3:0][3:0]       src_addr;
    logic [3:0][31:0]      src_data;

    logic [3:0]            ready0, ready1;
    logic [0:0]            we0;
    logic [0:0][3:0]       waddr0;
    logic [0:0][31:0]      wdata0;
    logic                  idle0;
    logic [1:0]            we1;
    logic [1:0][3:0]       waddr1;
    logic [1:0][31:0]      wdata1;
    logic                  idle1;

    int total = 0;
    int bad   = 0;
    bit checking = 0;

    // Reference model state, indexed [instance][...]; instance m has m+1 write ports.
    bit          m_held [2][4];
    logic [3:0]  m_addr [2][4];
    logic [31:0] m_data [2][4];
    int          m_rr   [2];
    bit          m_we   [2][2];
    logic [3:0]  m_waddr[2][2];
    logic [31:0] m_wdata[2][2];
    logic [3:0]  m_grant[2];
    logic [3:0]  m_ready[2];
    int          m_gsrc [2][2];
    int          m_ng   [2];

    wb_arbiter #(.DATA(32), .ADDR(4), .SRC(4), .WRITE(1)) dut0 (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_ready(ready0),
        .src_addr(src_addr), .src_data(src_data),
        .we_(we0), .waddr(waddr0), .wdata(wdata0), .idle(idle0)
    );

    wb_arbiter #(.DATA(32), .ADDR(4), .SRC(4), .WRITE(2)) dut1 (
        .clk(clk), .reset(reset), .src_valid(src_valid), .src_ready(ready1),
        .src_addr(src_addr), .src_data(src_data),
        .we_(we1), .waddr(waddr1), .wdata(wdata1), .idle(idle1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pick held sources in round-robin order, skipping addresses already chosen.
    task automatic modelComb(input int m);
        int  s;
        bit  clash;
        m_grant[m] = '0;
        m_ng[m]    = 0;
        for (int j = 0; j < 4; j++) begin
            s = (m_rr[m] + j) % 4;
            clash = 0;
            for (int g = 0; g < m_ng[m]; g++)
                if (m_addr[m][m_gsrc[m][g]] == m_addr[m][s]) clash = 1;
            if (m_held[m][s] && m_ng[m] < m + 1 && !clash) begin
                m_grant[m][s] = 1'b1;
                m_gsrc[m][m_ng[m]] = s;
                m_ng[m]++;
            end
        end
        for (int s2 = 0; s2 < 4; s2++)
            m_ready[m][s2] = !reset && (!m_held[m][s2] || m_grant[m][s2]);
    endtask

    task automatic modelEdge(input int m);
        if (reset) begin
            for (int s = 0; s < 4; s++) begin
                m_held[m][s] = 0;
                m_addr[m][s] = '0;
                m_data[m][s] = '0;
            end
            for (int k = 0; k < 2; k++) begin
                m_we[m][k] = 1;
                m_waddr[m][k] = '0;
                m_wdata[m][k] = '0;
            end
            m_rr[m] = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (k < m_ng[m]) begin
                    m_we[m][k]    = 0;
                    m_waddr[m][k] = m_addr[m][m_gsrc[m][k]];
                    m_wdata[m][k] = m_data[m][m_gsrc[m][k]];
                end else begin
                    m_we[m][k]    = 1;
                    m_waddr[m][k] = '0;
                    m_wdata[m][k] = '0;
                end
            end
            if (m_ng[m] > 0) m_rr[m] = (m_gsrc[m][m_ng[m] - 1] + 1) % 4;
            for (int s = 0; s < 4; s++) begin
                if (src_valid[s] && m_ready[m][s]) begin
                    m_held[m][s] = 1;
                    m_addr[m][s] = src_addr[s];
                    m_data[m][s] = src_data[s];
                end else if (m_grant[m][s]) begin
                    m_held[m][s] = 0;
                end
            end
        end
    endtask

    function automatic logic modelIdle(input int m);
        logic any_held;
        any_held = 0;
        for (int s = 0; s < 4; s++) any_held |= m_held[m][s];
        return reset || (!any_held && m_we[m][0] && m_we[m][1]);
    endfunction

    // Drive one cycle of inputs, compare both instances mid-cycle, then advance.
    task automatic applyStimulus(input logic r, input logic [3:0] v,
                                 input logic [3:0][3:0] a, input logic [3:0][31:0] d);
        reset     = r;
        src_valid = v;
        src_addr  = a;
        src_data  = d;
        #4;
        modelComb(0);
        modelComb(1);
        if (checking) begin
            checkOutput("ready0", ready0, m_ready[0]);
            checkOutput("we0",    we0,    m_we[0][0]);
            checkOutput("waddr0", waddr0, m_waddr[0][0]);
            checkOutput("wdata0", wdata0, m_wdata[0][0]);
            checkOutput("idle0",  idle0,  modelIdle(0));
            checkOutput("ready1", ready1, m_ready[1]);
            checkOutput("we1",    we1,    {m_we[1][1], m_we[1][0]});
            checkOutput("waddr1", waddr1, {m_waddr[1][1], m_waddr[1][0]});
            checkOutput("wdata1", wdata1, {m_wdata[1][1], m_wdata[1][0]});
            checkOutput("idle1",  idle1,  modelIdle(1));
        end
        @(posedge clk);
        modelEdge(0);
        modelEdge(1);
        checking = 1;
        #1;
    endtask

    task automatic idleCycle(input logic r);
        applyStimulus(r, 4'b0000, '0, '0);
    endtask

    initial begin
        logic [3:0][3:0]  a;
        logic [3:0][31:0] d;
        reset = 1'b1; src_valid = '0; src_addr = '0; src_data = '0;

        // Reset held for three cycles with every source presenting a result.
        a = '0; d = '0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b1111, a, d);

        // Single result from source 2.
        a = '0; d = '0; a[2] = 4'd5; d[2] = 32'hDEADBEEF;
        applyStimulus(1'b0, 4'b0100, a, d);
        idleCycle(1'b0);
        checkOutput("single_we",    we0,    1'b0);
        checkOutput("single_waddr", waddr0, 4'd5);
        checkOutput("single_wdata", wdata0, 32'hDEADBEEF);
        idleCycle(1'b0);
        checkOutput("single_we_off", we0,   1'b1);
        checkOutput("single_idle",   idle0, 1'b1);

        // All four sources at once, drained in index order on one port.
        idleCycle(1'b1);
        a = '0; d = '0;
        for (int i = 0; i < 4; i++) begin a[i] = 4'(i + 1); d[i] = 32'(100 + i); end
        applyStimulus(1'b0, 4'b1111, a, d);
        for (int i = 0; i < 4; i++) begin
            idleCycle(1'b0);
            checkOutput("rr_order", waddr0, 4'(i + 1));
        end

        // Two sources to the same register must not share a cycle.
        idleCycle(1'b1);
        a = '0; d = '0; a[0] = 4'd7; a[1] = 4'd7; d[0] = 32'h11; d[1] = 32'h22;
        applyStimulus(1'b0, 4'b0011, a, d);
        idleCycle(1'b0);
        checkOutput("same_addr_we_a",   we1, 2'b10);
        checkOutput("same_addr_data_a", wdata1[0], 32'h11);
        idleCycle(1'b0);
        checkOutput("same_addr_we_b",   we1, 2'b10);
        checkOutput("same_addr_addr_b", waddr1[0], 4'd7);
        checkOutput("same_addr_data_b", wdata1[0], 32'h22);

        // Back-to-back stream from source 1.
        idleCycle(1'b1);
        for (int i = 1; i <= 4; i++) begin
            a = '0; d = '0; a[1] = 4'd3; d[1] = 32'(i);
            applyStimulus(1'b0, 4'b0010, a, d);
            if (i > 1) checkOutput("stream_data", wdata0, 32'(i - 1));
        end
        idleCycle(1'b0);
        checkOutput("stream_last", wdata0, 32'd4);

        // Reset lands in the cycle source 3 is granted.
        idleCycle(1'b1);
        a = '0; d = '0; a[3] = 4'd9; d[3] = 32'hCAFE;
        applyStimulus(1'b0, 4'b1000, a, d);
        idleCycle(1'b1);
        checkOutput("rst_drop_we", we0, 1'b1);
        idleCycle(1'b0);
        checkOutput("rst_drop_idle", idle0, 1'b1);
        a = '0; d = '0;
        for (int i = 0; i < 4; i++) begin a[i] = 4'(10 + i); d[i] = 32'(i); end
        applyStimulus(1'b0, 4'b1111, a, d);
        idleCycle(1'b0);
        checkOutput("rst_ptr_zero", waddr0, 4'd10);

        // Random traffic with a narrow address range to provoke collisions.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                a[i] = 4'($urandom_range(0, 3));
                d[i] = $urandom;
            end
            applyStimulus(($urandom_range(0, 49) == 0), 4'($urandom), a, d);
        end
        for (int c = 0; c < 6; c++) idleCycle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter that sits directly upstream of the general-purpose register file.
- Collects results from SRC functional-unit producers through valid/ready handshakes and holds one pending result per source.
- Grants up to WRITE results per cycle in round-robin order.
- Drives the register-file write ports with registered, active-low write enables.

Parameters:
DATA, 32, bit width of a result / register
ADDR, 4, register address width
SRC, 4, number of producer sources (2..16)
WRITE, 1, number of register-file write ports (1..SRC)

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-high
src_valid  input  [SRC-1:0]  source i presents a result
src_ready  output  [SRC-1:0]  source i result accepted this cycle when valid&ready
src_addr  input  [SRC-1:0][ADDR-1:0]  destination register per source
src_data  input  [SRC-1:0][DATA-1:0]  result data per source
we_  output  [WRITE-1:0]  write enable to register file, active-low, registered
waddr  output  [WRITE-1:0][ADDR-1:0]  write address, registered
wdata  output  [WRITE-1:0][DATA-1:0]  write data, registered
idle  output  1  no held entries and no write issued this cycle

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high; it is sampled only on rising clk.
- Reset state: held[] = 0, rr_ptr = 0, we_ = all 1s, waddr = 0, wdata = 0.
- While reset = 1, src_ready = 0 and idle = 1; nothing is accepted.
- Reset mid-operation discards all held entries and any write registered for that edge. Post-reset we_ = all 1s.
- Holding register per source: held[i], h_addr[i], h_data[i].
- src_ready[i] = ~reset & (~held[i] | grant[i]), combinational. A source may hand over a new result in the same cycle its held entry is granted.
- Accept: valid&ready on cycle t loads the holding register; held[i] = 1 at t+1.
- Grant (combinational, each cycle):
  - Scan sources starting at rr_ptr, wrapping modulo SRC.
  - Grant each held source in scan order until WRITE grants are issued.
  - Skip a held source whose h_addr equals the address of a source already granted this cycle. It stays held and is retried next cycle.
- Grant k (k-th in scan order) drives port k at the next edge: we_[k] = 0, waddr[k] = h_addr, wdata[k] = h_data.
- Unused ports: we_ = 1, waddr = 0, wdata = 0.
- Latency: accepted at t, earliest write on ports at t+2. The register file captures it at the end of t+2; readable from t+3.
- Round-robin pointer: if any grant, rr_ptr <= (last granted index + 1) mod SRC; otherwise unchanged.
- Fairness: a continuously held source is granted within ceil(SRC/WRITE) + (same-address deferrals) cycles.
- Held entry grant and new accept in the same cycle: the outgoing entry goes to the output register, the incoming entry overwrites the holding register, held stays 1.
- Address 0 is forwarded like any other address; zero-register suppression is the register file's job.
- Ordering: results from one source are written in acceptance order. No ordering guarantee exists between different sources.
- Equal-address results from different sources are never written in the same cycle.
- idle = ~|held & &we_.

Test Plan:
- Params SRC=4, WRITE=1. Pulse reset high 3 cycles while src_valid = 4'b1111 -> src_ready = 0, we_ = 1, idle = 1 throughout. First acceptance occurs on the cycle after reset falls.
- Single result: src 2 presents addr 5, data 0xDEADBEEF at t -> we_ = 0, waddr = 5, wdata = 0xDEADBEEF at t+2 only; idle returns to 1 at t+3.
- All four sources valid at t with addrs 1,2,3,4 -> writes in order src0, src1, src2, src3 on t+2..t+5 (rr_ptr = 0). Source i's src_ready is high again in the cycle it is granted.
- WRITE=2, src0 and src1 both target addr 7 (data 0x11, 0x22) -> t+2: one port writes 0x11, other port we_ = 1; t+3: addr 7 written with 0x22.
- Back-to-back: src 1 valid every cycle with data 1,2,3,4 (only source) -> src_ready held high, wdata = 1,2,3,4 on consecutive cycles starting t+2.
- Reset asserted in the cycle src 3 is granted -> no write appears after the reset edge; held cleared; rr_ptr = 0.
